// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the unified-memory arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory port bundle of mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_rreq;
    logic              mem_wreq;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, mem_rreq, mem_wreq, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output ram_en, ram_we, ram_addr, ram_wdata, stall
    );

    // Pipeline + memory side
    modport master (
        output if_req, if_addr, mem_rreq, mem_wreq, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata, stall
    );

endinterface

// File: rtl/mem_arbiter_fetch_buffer.sv
// rtl/mem_arbiter_fetch_buffer.sv - one-entry instruction buffer (tag, data, valid)
module fetch_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_tag,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] inval_addr
);

    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            tag_d   = load_tag;
            data_d  = load_data;
            valid_d = 1'b1;
        end
        // A store to the buffered word makes the copy stale
        if (inval && (inval_addr == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign hit      = valid_q && (lookup_addr == tag_q);
    assign hit_data = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data over fetch, IDLE/BUSY/RESP sequencing
// Optional one-entry fetch buffer enabled by defining IBUF_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_req;
    assign mem_req = bus.mem_rreq | bus.mem_wreq;

`ifdef IBUF_EN
    logic              ibuf_hit;
    logic              ibuf_load;
    logic              ibuf_inval;
    logic [DATA_W-1:0] ibuf_data;

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (bus.if_addr),
        .hit         (ibuf_hit),
        .hit_data    (ibuf_data),
        .load        (ibuf_load),
        .load_tag    (addr_q),
        .load_data   (bus.ram_rdata),
        .inval       (ibuf_inval),
        .inval_addr  (bus.mem_addr)
    );
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef IBUF_EN
        ibuf_load   = 1'b0;
        ibuf_inval  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Data side wins; a simultaneous read+write request is a write
                if (mem_req) begin
                    addr_d  = bus.mem_addr;
                    we_d    = bus.mem_wreq;
                    wdata_d = bus.mem_wdata;
                    owner_d = OWN_MEM;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef IBUF_EN
                    ibuf_inval = bus.mem_wreq;
`endif
                end
`ifdef IBUF_EN
                else if (bus.if_req && ibuf_hit) begin
                    owner_d    = OWN_IF;
                    if_rdata_d = ibuf_data;
                    state_d    = RESP;
                end
`endif
                else if (bus.if_req) begin
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    owner_d = OWN_IF;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = bus.ram_rdata;
                    end else begin
                        if_rdata_d = bus.ram_rdata;
`ifdef IBUF_EN
                        ibuf_load  = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Ready cycle: never accepts, so a still-held request is not taken twice
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_en    = (state_q == BUSY);
    assign bus.ram_we    = (state_q == BUSY) && we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

    assign bus.if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.mem_ready = (state_q == RESP) && (owner_q == OWN_MEM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;

    assign bus.stall = (bus.if_req & ~bus.if_ready) | (mem_req & ~bus.mem_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (LATENCY=2, IBUF_EN aware)
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dif ();

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } mem_exp_t;

    logic [31:0] if_sb[$];
    mem_exp_t    mem_sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tb_mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dif.ram_rdata = tb_mem[dif.ram_addr[11:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA500_0000 ^ i;
            tb_mem[2] <= 32'hE3A0_1A01;
            tb_mem[4] <= 32'h1234_5678;
            tb_mem[8] <= 32'h0BAD_C0DE;
        end else if (dif.ram_en && dif.ram_we) begin
            tb_mem[dif.ram_addr[11:2]] <= dif.ram_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on each ready pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.if_ready) begin
                if (if_sb.size() == 0) check_eq("if_ready_unexpected", 32'd1, 32'd0);
                else check_eq("if_rdata", dif.if_rdata, if_sb.pop_front());
            end
            if (dif.mem_ready) begin
                if (mem_sb.size() == 0) check_eq("mem_ready_unexpected", 32'd1, 32'd0);
                else begin
                    mem_exp_t e;
                    e = mem_sb.pop_front();
                    if (e.chk) check_eq("mem_rdata", dif.mem_rdata, e.data);
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_lat,
                            input string tag);
        int lat;
        bit en_seen;
        bit done;
        next_cyc();
        dif.if_req  = 1'b1;
        dif.if_addr = a;
        if_sb.push_back(exp);
        lat = 0; en_seen = 0; done = 0;
        while (!done && lat < 20) begin
            next_cyc();
            lat++;
            if (dif.ram_en) en_seen = 1;
            if (dif.if_ready) done = 1;
        end
        dif.if_req = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_ram_en_seen"}, {31'd0, en_seen}, {31'd0, exp_lat > 1});
    endtask

    task automatic do_mem(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input bit chk, input string tag);
        int lat;
        bit we_seen;
        bit done;
        mem_exp_t e;
        next_cyc();
        dif.mem_rreq  = rd;
        dif.mem_wreq  = wr;
        dif.mem_addr  = a;
        dif.mem_wdata = wd;
        e.chk = chk;
        e.data = exp;
        mem_sb.push_back(e);
        lat = 0; we_seen = 0; done = 0;
        while (!done && lat < 20) begin
            next_cyc();
            lat++;
            if (dif.ram_we) we_seen = 1;
            if (dif.mem_ready) done = 1;
        end
        dif.mem_rreq = 1'b0;
        dif.mem_wreq = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_ram_we_seen"}, {31'd0, we_seen}, {31'd0, wr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_exp_t e;
        rst = 1'b1;
        dif.if_req = 1'b0;  dif.if_addr = '0;
        dif.mem_rreq = 1'b0; dif.mem_wreq = 1'b0;
        dif.mem_addr = '0;  dif.mem_wdata = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("rst_if_ready", {31'd0, dif.if_ready}, 32'd0);
        check_eq("rst_mem_ready", {31'd0, dif.mem_ready}, 32'd0);
        check_eq("rst_ram_en", {31'd0, dif.ram_en}, 32'd0);
        check_eq("rst_ram_we", {31'd0, dif.ram_we}, 32'd0);
        check_eq("rst_stall", {31'd0, dif.stall}, 32'd0);
        check_eq("rst_ram_addr", dif.ram_addr, 32'd0);
        check_eq("rst_ram_wdata", dif.ram_wdata, 32'd0);
        check_eq("rst_if_rdata", dif.if_rdata, 32'd0);
        check_eq("rst_mem_rdata", dif.mem_rdata, 32'd0);

        // Single fetch, cycle by cycle
        next_cyc();
        dif.if_req = 1'b1; dif.if_addr = 32'h8;
        if_sb.push_back(32'hE3A0_1A01);
        #1;
        check_eq("f_c0_stall", {31'd0, dif.stall}, 32'd1);
        check_eq("f_c0_ram_en", {31'd0, dif.ram_en}, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next_cyc();
            check_eq($sformatf("f_c%0d_ram_en", c), {31'd0, dif.ram_en}, 32'd1);
            check_eq($sformatf("f_c%0d_ram_addr", c), dif.ram_addr, 32'h8);
            check_eq($sformatf("f_c%0d_stall", c), {31'd0, dif.stall}, 32'd1);
        end
        next_cyc();
        check_eq("f_c3_if_ready", {31'd0, dif.if_ready}, 32'd1);
        check_eq("f_c3_if_rdata", dif.if_rdata, 32'hE3A0_1A01);
        check_eq("f_c3_stall", {31'd0, dif.stall}, 32'd0);
        check_eq("f_c3_ram_en", {31'd0, dif.ram_en}, 32'd0);
        dif.if_req = 1'b0;

        // Contention: write wins, fetch follows
        next_cyc();
        dif.if_req = 1'b1; dif.if_addr = 32'h10;
        dif.mem_wreq = 1'b1; dif.mem_addr = 32'h400; dif.mem_wdata = 32'h1000;
        e.chk = 0; e.data = '0;
        mem_sb.push_back(e);
        if_sb.push_back(32'h1234_5678);
        for (int c = 1; c <= 2; c++) begin
            next_cyc();
            check_eq($sformatf("ct_c%0d_ram_we", c), {31'd0, dif.ram_we}, 32'd1);
            check_eq($sformatf("ct_c%0d_ram_addr", c), dif.ram_addr, 32'h400);
            check_eq($sformatf("ct_c%0d_ram_wdata", c), dif.ram_wdata, 32'h1000);
        end
        next_cyc();
        check_eq("ct_c3_mem_ready", {31'd0, dif.mem_ready}, 32'd1);
        check_eq("ct_c3_if_ready", {31'd0, dif.if_ready}, 32'd0);
        next_cyc();
        dif.mem_wreq = 1'b0;
        #1;
        check_eq("ct_c4_ram_en", {31'd0, dif.ram_en}, 32'd0);
        check_eq("ct_c4_stall", {31'd0, dif.stall}, 32'd1);
        for (int c = 5; c <= 6; c++) begin
            next_cyc();
            check_eq($sformatf("ct_c%0d_ram_en", c), {31'd0, dif.ram_en}, 32'd1);
            check_eq($sformatf("ct_c%0d_ram_we", c), {31'd0, dif.ram_we}, 32'd0);
            check_eq($sformatf("ct_c%0d_ram_addr", c), dif.ram_addr, 32'h10);
        end
        next_cyc();
        check_eq("ct_c7_if_ready", {31'd0, dif.if_ready}, 32'd1);
        dif.if_req = 1'b0;

        do_mem(1, 0, 32'h400, 32'h0, 32'h1000, 1, "rd400");

        // Simultaneous read+write behaves as a write
        do_mem(1, 1, 32'h404, 32'hCAFE_F00D, 32'h0, 0, "dbl404");
        do_mem(1, 0, 32'h404, 32'h0, 32'hCAFE_F00D, 1, "rd404");

        // Reset in the first BUSY cycle of a fetch
        next_cyc();
        dif.if_req = 1'b1; dif.if_addr = 32'h8;
        if_sb.push_back(32'hE3A0_1A01);
        next_cyc();
        check_eq("rm_c1_ram_en", {31'd0, dif.ram_en}, 32'd1);
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        #1;
        check_eq("rm_c2_ram_en", {31'd0, dif.ram_en}, 32'd0);
        check_eq("rm_c2_if_ready", {31'd0, dif.if_ready}, 32'd0);
        for (int c = 3; c <= 4; c++) begin
            next_cyc();
            check_eq($sformatf("rm_c%0d_if_ready", c), {31'd0, dif.if_ready}, 32'd0);
            check_eq($sformatf("rm_c%0d_ram_en", c), {31'd0, dif.ram_en}, 32'd1);
        end
        next_cyc();
        check_eq("rm_c5_if_ready", {31'd0, dif.if_ready}, 32'd1);
        dif.if_req = 1'b0;

        // Repeat fetch, then store to the same word
        do_fetch(32'h20, 32'h0BAD_C0DE, 3, "f20_first");
`ifdef IBUF_EN
        do_fetch(32'h20, 32'h0BAD_C0DE, 1, "f20_second");
`else
        do_fetch(32'h20, 32'h0BAD_C0DE, 3, "f20_second");
`endif
        do_mem(0, 1, 32'h20, 32'h1111_2222, 32'h0, 0, "wr20");
        do_fetch(32'h20, 32'h1111_2222, 3, "f20_after_wr");
        do_fetch(32'h10, 32'h1234_5678, 3, "f10");

        next_cyc();
        next_cyc();
        check_eq("if_sb_drained", 32'(if_sb.size()), 32'd0);
        check_eq("mem_sb_drained", 32'(mem_sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
